// File: rtl/lut_mult_pkg.sv
// Shared types and the digit recoding helper for the digit-serial LUT multiplier front end.
package lut_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  localparam int DEFAULT_DIGIT_W = 4;

  // One's complement of the digit when negating, plus the rippled carry; MSB of the result is carry-out.
  function automatic logic [DEFAULT_DIGIT_W:0] recode_digit(
    input logic [DEFAULT_DIGIT_W-1:0] digit,
    input logic                       neg,
    input logic                       carry
  );
    return {1'b0, digit ^ {DEFAULT_DIGIT_W{neg}}} + {{DEFAULT_DIGIT_W{1'b0}}, carry};
  endfunction

endpackage

// File: rtl/digit_negate_cell.sv
// Conditional complement of one digit plus carry-in; chaining cells LSB-first yields a two's-complement magnitude.
module digit_negate_cell
  import lut_mult_pkg::*;
#(
  parameter int DIGIT_W = DEFAULT_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic               invert,
  input  logic               carry,
  output logic [DIGIT_W-1:0] mag_digit,
  output logic               carry_next
);

  // The package helper is fixed at the default width; other widths use the same expression directly.
  if (DIGIT_W == DEFAULT_DIGIT_W) begin : g_pkg
    assign {carry_next, mag_digit} = recode_digit(digit, invert, carry);
  end else begin : g_generic
    assign {carry_next, mag_digit} = {1'b0, digit ^ {DIGIT_W{invert}}} + {{DIGIT_W{1'b0}}, carry};
  end

endmodule

// File: rtl/operand_digit_recoder.sv
// Accepts one operand and streams its magnitude LSB digit first, one digit per accepted handshake.
module operand_digit_recoder
  import lut_mult_pkg::*;
#(
  parameter  int DATA_W     = 16,
  parameter  int DIGIT_W    = DEFAULT_DIGIT_W,
  localparam int NUM_DIGITS = DATA_W / DIGIT_W,
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIGIT_W-1:0] out_digit,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_neg
);

  if ((DATA_W % DIGIT_W) != 0) begin : g_bad_width
    $fatal(1, "operand_digit_recoder: DATA_W must be a multiple of DIGIT_W");
  end

  state_t             state;
  logic [DATA_W-1:0]  opnd;
  logic               neg;
  logic               carry;
  logic [IDX_W-1:0]   idx;

  logic [DIGIT_W-1:0] slice;
  logic [DIGIT_W-1:0] mag_digit;
  logic               carry_next;
  logic               emitting;
  logic               at_last;

  assign slice    = opnd[int'(idx) * DIGIT_W +: DIGIT_W];
  assign emitting = (state == EMIT);
  assign at_last  = (idx == IDX_W'(NUM_DIGITS - 1));

  digit_negate_cell #(
    .DIGIT_W (DIGIT_W)
  ) u_negate (
    .digit      (slice),
    .invert     (neg),
    .carry      (carry),
    .mag_digit  (mag_digit),
    .carry_next (carry_next)
  );

  // Carry seeds with neg so the first digit gets the +1 of the two's-complement negation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      opnd  <= '0;
      neg   <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            opnd  <= in_data;
            neg   <= in_signed & in_data[DATA_W-1];
            carry <= in_signed & in_data[DATA_W-1];
            idx   <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (at_last) begin
              idx   <= '0;
              state <= IDLE;
            end else begin
              carry <= carry_next;
              idx   <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are derived only from registers, and are forced to zero outside EMIT.
  assign in_ready  = !emitting;
  assign out_valid = emitting;
  assign out_digit = emitting ? mag_digit : '0;
  assign out_idx   = emitting ? idx : '0;
  assign out_last  = emitting & at_last;
  assign out_neg   = emitting & neg;

endmodule

// File: tb/tb_operand_digit_recoder.sv
// Directed checks of the digit-serial recoder at 16/4 and 4/4 widths, plus a back-to-back scoreboard run.
module tb_operand_digit_recoder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_last, out_neg;
  logic [15:0] in_data;
  logic [3:0]  out_digit;
  logic [1:0]  out_idx;

  logic        n_in_valid, n_in_ready, n_in_signed, n_out_valid, n_out_ready, n_out_last, n_out_neg;
  logic [3:0]  n_in_data, n_out_digit;
  logic [0:0]  n_out_idx;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  operand_digit_recoder #(.DATA_W(16), .DIGIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_idx(out_idx), .out_last(out_last), .out_neg(out_neg)
  );

  operand_digit_recoder #(.DATA_W(4), .DIGIT_W(4)) dut_narrow (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_signed(n_in_signed),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_digit(n_out_digit),
    .out_idx(n_out_idx), .out_last(n_out_last), .out_neg(n_out_neg)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand for a single accepting edge, then scrambles the inputs.
  task automatic accept_operand(input logic [15:0] data, input logic sgn);
    in_valid  = 1'b1;
    in_data   = data;
    in_signed = sgn;
    step();
    in_valid  = 1'b0;
    in_data   = ~data;
    in_signed = ~sgn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++;
    if ({in_ready, out_valid, out_digit, out_idx, out_last, out_neg} !== {1'b1, 1'b0, 4'h0, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_state: got rdy/vld/dig/idx/last/neg=%b/%b/%h/%0d/%b/%b want 1/0/0/0/0/0",
               in_ready, out_valid, out_digit, out_idx, out_last, out_neg);
    end
    n_cmp++;
    if ({n_in_ready, n_out_valid, n_out_digit, n_out_last, n_out_neg} !== {1'b1, 1'b0, 4'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL reset_state_narrow: got rdy/vld/dig/last/neg=%b/%b/%h/%b/%b want 1/0/0/0/0",
               n_in_ready, n_out_valid, n_out_digit, n_out_last, n_out_neg);
    end
    rst_n = 1'b1;
    step();
  endtask

  // Streams one operand with out_ready held high and checks every digit against a hand-computed magnitude.
  task automatic test_stream(input string name, input logic [15:0] data, input logic sgn,
                             input logic [15:0] exp_mag, input logic exp_neg);
    out_ready = 1'b1;
    accept_operand(data, sgn);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid, out_digit, out_idx, out_last, out_neg, in_ready} !==
          {1'b1, exp_mag[i*4 +: 4], 2'(i), (i == 3), exp_neg, 1'b0}) begin
        n_err++;
        $display("[TB] FAIL %s_digit%0d: got vld/dig/idx/last/neg/rdy=%b/%h/%0d/%b/%b/%b want 1/%h/%0d/%b/%b/0",
                 name, i, out_valid, out_digit, out_idx, out_last, out_neg, in_ready,
                 exp_mag[i*4 +: 4], i, (i == 3), exp_neg);
      end
      step();
    end
    n_cmp++;
    if ({in_ready, out_valid, out_idx, out_last} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL %s_return_idle: got rdy/vld/idx/last=%b/%b/%0d/%b want 1/0/0/0",
               name, in_ready, out_valid, out_idx, out_last);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_mag;
    exp_mag   = 16'h0C59;
    out_ready = 1'b1;
    accept_operand(16'hF3A7, 1'b1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          n_cmp++;
          if ({out_valid, out_digit, out_idx, out_last, out_neg} !== {1'b1, 4'h5, 2'd1, 1'b0, 1'b1}) begin
            n_err++;
            $display("[TB] FAIL stall_hold%0d: got vld/dig/idx/last/neg=%b/%h/%0d/%b/%b want 1/5/1/0/1",
                     k, out_valid, out_digit, out_idx, out_last, out_neg);
          end
          step();
        end
        out_ready = 1'b1;
      end
      n_cmp++;
      if ({out_valid, out_digit, out_idx, out_last, out_neg} !== {1'b1, exp_mag[i*4 +: 4], 2'(i), (i == 3), 1'b1}) begin
        n_err++;
        $display("[TB] FAIL stall_digit%0d: got vld/dig/idx/last/neg=%b/%h/%0d/%b/%b want 1/%h/%0d/%b/1",
                 i, out_valid, out_digit, out_idx, out_last, out_neg, exp_mag[i*4 +: 4], i, (i == 3));
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    accept_operand(16'hF3A7, 1'b1);
    step();
    step();
    n_cmp++;
    if ({out_valid, out_idx, out_digit} !== {1'b1, 2'd2, 4'hC}) begin
      n_err++;
      $display("[TB] FAIL midreset_pre: got vld/idx/dig=%b/%0d/%h want 1/2/c", out_valid, out_idx, out_digit);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid, in_ready, out_digit, out_idx, out_last, out_neg} !== {1'b0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL midreset_post: got vld/rdy/dig/idx/last/neg=%b/%b/%h/%0d/%b/%b want 0/1/0/0/0/0",
               out_valid, in_ready, out_digit, out_idx, out_last, out_neg);
    end
    test_stream("after_reset", 16'h0012, 1'b1, 16'h0012, 1'b0);
  endtask

  task automatic test_narrow();
    logic [3:0] x, exp_mag;
    logic       exp_neg;
    n_out_ready = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      for (int v = 0; v < 16; v++) begin
        x           = 4'(v);
        exp_neg     = (s == 1) && x[3];
        exp_mag     = exp_neg ? 4'(~x + 4'd1) : x;
        n_in_valid  = 1'b1;
        n_in_data   = x;
        n_in_signed = (s == 1);
        step();
        n_in_valid  = 1'b0;
        n_in_data   = ~x;
        n_cmp++;
        if ({n_out_valid, n_out_digit, n_out_idx, n_out_last, n_out_neg, n_in_ready} !==
            {1'b1, exp_mag, 1'b0, 1'b1, exp_neg, 1'b0}) begin
          n_err++;
          $display("[TB] FAIL narrow_s%0d_x%h: got vld/dig/idx/last/neg/rdy=%b/%h/%0d/%b/%b/%b want 1/%h/0/1/%b/0",
                   s, x, n_out_valid, n_out_digit, n_out_idx, n_out_last, n_out_neg, n_in_ready, exp_mag, exp_neg);
        end
        step();
      end
    end
    n_in_valid  = 1'b1;
    n_in_data   = 4'hD;
    n_in_signed = 1'b1;
    step();
    n_in_valid  = 1'b0;
    n_cmp++;
    if ({n_out_digit, n_out_last, n_out_neg} !== {4'h3, 1'b1, 1'b1}) begin
      n_err++;
      $display("[TB] FAIL narrow_minus3: got dig/last/neg=%h/%b/%b want 3/1/1", n_out_digit, n_out_last, n_out_neg);
    end
    step();
    n_cmp++;
    if ({n_in_ready, n_out_valid} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL narrow_idle: got rdy/vld=%b/%b want 1/0", n_in_ready, n_out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] data, exp_mag, got;
    logic        sgn, exp_neg, done;
    int          next_idx, cyc;
    for (int n = 0; n < 12; n++) begin
      data    = (n == 0) ? 16'h8000 : (n == 1) ? 16'h0000 : 16'($urandom);
      sgn     = (n < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_neg = sgn && data[15];
      exp_mag = exp_neg ? 16'(~data + 16'd1) : data;
      cyc     = 0;
      while (!in_ready && cyc < 50) begin
        step();
        cyc++;
      end
      n_cmp++;
      if (!in_ready) begin
        n_err++;
        $display("[TB] FAIL b2b_ready_timeout%0d: got in_ready=%b want 1", n, in_ready);
      end
      accept_operand(data, sgn);
      got      = '0;
      next_idx = 0;
      done     = 1'b0;
      cyc      = 0;
      while (!done && cyc < 200) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && in_ready) begin
          n_cmp++;
          n_err++;
          $display("[TB] FAIL b2b_ready_in_emit%0d: got in_ready=1 want 0", n);
        end
        if (out_valid && out_ready) begin
          n_cmp++;
          if ({out_idx, out_neg, out_last} !== {2'(next_idx), exp_neg, (next_idx == 3)}) begin
            n_err++;
            $display("[TB] FAIL b2b_seq%0d: got idx/neg/last=%0d/%b/%b want %0d/%b/%b",
                     n, out_idx, out_neg, out_last, next_idx, exp_neg, (next_idx == 3));
          end
          got[int'(out_idx)*4 +: 4] = out_digit;
          done = out_last;
          next_idx++;
        end
        step();
        cyc++;
      end
      n_cmp++;
      if (!done || got !== exp_mag) begin
        n_err++;
        $display("[TB] FAIL b2b_mag%0d: data=%h signed=%b got %h done=%b want %h", n, data, sgn, got, done, exp_mag);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    in_valid = 1'b0; in_data = '0; in_signed = 1'b0; out_ready = 1'b1;
    n_in_valid = 1'b0; n_in_data = '0; n_in_signed = 1'b0; n_out_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_stream("minus_one", 16'hFFFF, 1'b1, 16'h0001, 1'b1);
    test_stream("most_neg", 16'h8000, 1'b1, 16'h8000, 1'b1);
    test_stream("unsigned_8000", 16'h8000, 1'b0, 16'h8000, 1'b0);
    test_stream("unsigned_f3a7", 16'hF3A7, 1'b0, 16'hF3A7, 1'b0);
    test_stream("zero", 16'h0000, 1'b1, 16'h0000, 1'b0);
    test_backpressure();
    test_mid_reset();
    test_narrow();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
